// File: rtl/i2s_sample_scheduler.sv
// Sample-rate scheduler and two-source arbiter/mixer feeding an I2S transmitter.
// Optional build macro UNDERRUN_MUTE_EN: underrun frames output silence instead of repeating the last sample.
module i2s_sample_scheduler #(
  parameter int DW         = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int FRAME_DIV  = 2500
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          en,
  input  logic [1:0]                    mode,
  input  logic                          src0_valid,
  output logic                          src0_ready,
  input  logic [DW-1:0]                 src0_l,
  input  logic [DW-1:0]                 src0_r,
  input  logic                          src1_valid,
  output logic                          src1_ready,
  input  logic [DW-1:0]                 src1_l,
  input  logic [DW-1:0]                 src1_r,
  output logic [DW-1:0]                 Ldata,
  output logic [DW-1:0]                 Rdata,
  output logic                          sample_clk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [15:0]                   underrun_cnt
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int CW   = $clog2(FRAME_DIV);
  localparam int HALF = FRAME_DIV / 2;

  localparam logic [1:0] MODE_SRC0 = 2'b00;
  localparam logic [1:0] MODE_SRC1 = 2'b01;
  localparam logic [1:0] MODE_RR   = 2'b10;
  localparam logic [1:0] MODE_MIX  = 2'b11;

  logic [CW-1:0]   fcnt;
  logic [LW-1:0]   level;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [2*DW-1:0] mem [FIFO_DEPTH];
  logic            rr_next;   // 0: src0 wins a tie next, 1: src1 wins

  logic            full;
  logic            empty;
  logic            frame_start;
  logic            pop;
  logic            underrun_ev;
  logic            acc0;
  logic            acc1;
  logic            push;
  logic [2*DW-1:0] push_data;

  // Signed add of two DW-bit samples, clamped to the DW-bit range.
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {a[DW-1], a} + {b[DW-1], b};
    if (s[DW] != s[DW-1])
      sat_add = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    else
      sat_add = s[DW-1:0];
  endfunction

  assign full        = (level == LW'(FIFO_DEPTH));
  assign empty       = (level == '0);
  assign frame_start = en && (fcnt == '0);
  assign pop         = frame_start && !empty;
  assign underrun_ev = frame_start && empty;
  assign fifo_level  = level;

  // Handshake: a source transfers a sample on a clock edge where its valid and
  // ready are both high; ready is combinational and at most one push per cycle.
  always_comb begin
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    if (en && !full) begin
      case (mode)
        MODE_SRC0: src0_ready = 1'b1;
        MODE_SRC1: src1_ready = 1'b1;
        MODE_RR: begin
          if (src0_valid && (!src1_valid || !rr_next))
            src0_ready = 1'b1;
          else if (src1_valid)
            src1_ready = 1'b1;
        end
        default: begin
          src0_ready = src0_valid && src1_valid;
          src1_ready = src0_valid && src1_valid;
        end
      endcase
    end
  end

  always_comb begin
    acc0      = src0_valid && src0_ready;
    acc1      = src1_valid && src1_ready;
    push      = acc0 || acc1;
    push_data = {src0_l, src0_r};
    if (mode == MODE_MIX)
      push_data = {sat_add(src0_l, src1_l), sat_add(src0_r, src1_r)};
    else if (acc1)
      push_data = {src1_l, src1_r};
  end

  always_ff @(posedge clk) begin
    if (RST || !en)
      fcnt <= '0;
    else if (fcnt == CW'(FRAME_DIV - 1))
      fcnt <= '0;
    else
      fcnt <= fcnt + 1'b1;
  end

  // Disabling the scheduler flushes the queue along with the frame counter.
  always_ff @(posedge clk) begin
    if (RST || !en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (en && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (RST)
      rr_next <= 1'b0;
    else if (mode == MODE_RR && push)
      rr_next <= acc0;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      Ldata        <= '0;
      Rdata        <= '0;
      sample_clk   <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      sample_clk <= en && (fcnt < CW'(HALF));
      if (pop) begin
        {Ldata, Rdata} <= mem[rd_ptr];
      end else if (underrun_ev) begin
        underrun <= 1'b1;
        if (underrun_cnt != 16'hFFFF)
          underrun_cnt <= underrun_cnt + 16'd1;
`ifdef UNDERRUN_MUTE_EN
        Ldata <= '0;
        Rdata <= '0;
`else
        Ldata <= Ldata;
        Rdata <= Rdata;
`endif
      end
    end
  end

endmodule

// File: tb/tb_i2s_sample_scheduler.sv
// Directed bench for i2s_sample_scheduler: ready-table vectors, mix table, and frame-level sequences.
module tb_i2s_sample_scheduler;

  localparam int DW    = 24;
  localparam int DEPTH = 4;
  localparam int FDIV  = 2500;
  localparam int LW    = $clog2(DEPTH) + 1;

`ifdef UNDERRUN_MUTE_EN
  localparam logic [DW-1:0] UR_L = 24'h000000;
  localparam logic [DW-1:0] UR_R = 24'h000000;
`else
  localparam logic [DW-1:0] UR_L = 24'h123456;
  localparam logic [DW-1:0] UR_R = 24'hFEDCBA;
`endif

  logic          clk;
  logic          RST;
  logic          en;
  logic [1:0]    mode;
  logic          src0_valid;
  logic          src0_ready;
  logic [DW-1:0] src0_l;
  logic [DW-1:0] src0_r;
  logic          src1_valid;
  logic          src1_ready;
  logic [DW-1:0] src1_l;
  logic [DW-1:0] src1_r;
  logic [DW-1:0] Ldata;
  logic [DW-1:0] Rdata;
  logic          sample_clk;
  logic [LW-1:0] fifo_level;
  logic          underrun;
  logic [15:0]   underrun_cnt;

  i2s_sample_scheduler #(.DW(DW), .FIFO_DEPTH(DEPTH), .FRAME_DIV(FDIV)) dut (
    .clk(clk), .RST(RST), .en(en), .mode(mode),
    .src0_valid(src0_valid), .src0_ready(src0_ready), .src0_l(src0_l), .src0_r(src0_r),
    .src1_valid(src1_valid), .src1_ready(src1_ready), .src1_l(src1_l), .src1_r(src1_r),
    .Ldata(Ldata), .Rdata(Rdata), .sample_clk(sample_clk), .fifo_level(fifo_level),
    .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  // Clock and reference frame counter.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int m_fcnt;
  always @(posedge clk) begin
    if (RST || !en)
      m_fcnt <= 0;
    else if (m_fcnt == FDIV - 1)
      m_fcnt <= 0;
    else
      m_fcnt <= m_fcnt + 1;
  end

  typedef struct {
    logic [1:0] mode;
    logic       v0;
    logic       v1;
    logic       e0;
    logic       e1;
  } rdy_vec_t;

  typedef struct {
    logic [DW-1:0] l0;
    logic [DW-1:0] r0;
    logic [DW-1:0] l1;
    logic [DW-1:0] r1;
    logic [DW-1:0] exp_l;
    logic [DW-1:0] exp_r;
  } mix_vec_t;

  rdy_vec_t          rdy_tbl[11];
  mix_vec_t          mix_tbl[4];
  logic [2*DW-1:0]   exp_q[$];
  logic [2*DW-1:0]   exp_e;
  int                n_vec;
  int                n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Stop at the negedge inside the next cycle whose frame count is 0.
  task automatic next_fcnt0();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_fcnt != 0 && k < FDIV + 5);
    if (m_fcnt != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_sync: got fcnt %0d expected 0", m_fcnt);
    end
  endtask

  initial begin
    int hi;
    int ok;
    n_vec = 0;
    n_err = 0;

    rdy_tbl[0]  = '{2'b00, 1'b1, 1'b1, 1'b1, 1'b0};
    rdy_tbl[1]  = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    rdy_tbl[2]  = '{2'b01, 1'b1, 1'b1, 1'b0, 1'b1};
    rdy_tbl[3]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b1};
    rdy_tbl[4]  = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b0};
    rdy_tbl[5]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b1};
    rdy_tbl[6]  = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b0};
    rdy_tbl[7]  = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    rdy_tbl[8]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1};
    rdy_tbl[9]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0};
    rdy_tbl[10] = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0};

    mix_tbl[0] = '{24'h7FFFFF, 24'h800000, 24'h000001, 24'hFFFFFF, 24'h7FFFFF, 24'h800000};
    mix_tbl[1] = '{24'h000010, 24'h000005, 24'hFFFFF0, 24'h000003, 24'h000000, 24'h000008};
    mix_tbl[2] = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF};
    mix_tbl[3] = '{24'h400000, 24'hFFFFFF, 24'h3FFFFF, 24'hFFFFFF, 24'h7FFFFF, 24'hFFFFFE};

    // Reset state.
    RST = 1'b1; en = 1'b0; mode = 2'b00;
    src0_valid = 1'b0; src0_l = '0; src0_r = '0;
    src1_valid = 1'b0; src1_l = '0; src1_r = '0;
    cyc(3);
    src0_valid = 1'b1;
    #1;
    chk("rst_ldata", Ldata, 0);
    chk("rst_rdata", Rdata, 0);
    chk("rst_sclk", sample_clk, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ucnt", underrun_cnt, 0);
    chk("dis_ready0", src0_ready, 0);
    chk("dis_ready1", src1_ready, 0);
    src0_valid = 1'b0;
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);

    // Ready generation per mode with an empty FIFO; valids withdrawn before each edge.
    en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      mode = rdy_tbl[i].mode;
      src0_valid = rdy_tbl[i].v0;
      src1_valid = rdy_tbl[i].v1;
      #1;
      chk($sformatf("rdy_tbl%0d_r0", i), src0_ready, rdy_tbl[i].e0);
      chk($sformatf("rdy_tbl%0d_r1", i), src1_ready, rdy_tbl[i].e1);
      #1;
      src0_valid = 1'b0;
      src1_valid = 1'b0;
      @(negedge clk);
    end

    // Single push in mode 00 on the first enabled (frame-start) cycle.
    RST = 1'b1; en = 1'b0; mode = 2'b00;
    cyc(2);
    RST = 1'b0;
    @(negedge clk);
    en = 1'b1;
    src0_valid = 1'b1; src0_l = 24'h123456; src0_r = 24'hFEDCBA;
    @(negedge clk);
    src0_valid = 1'b0;
    chk("t1_level_after_push", fifo_level, 1);
    chk("t1_first_frame_underrun", underrun, 1);
    chk("t1_first_ucnt", underrun_cnt, 1);
    chk("t1_ldata_first_frame", Ldata, 0);
    next_fcnt0();
    @(negedge clk);
    chk("t1_ldata", Ldata, 24'h123456);
    chk("t1_rdata", Rdata, 24'hFEDCBA);
    chk("t1_level_after_pop", fifo_level, 0);
    hi = 0;
    ok = 0;
    for (int i = 0; i < FDIV; i++) begin
      if (sample_clk) hi++;
      if (Ldata == 24'h123456 && Rdata == 24'hFEDCBA) ok++;
      @(negedge clk);
    end
    chk("t1_sclk_high_cycles", hi, FDIV / 2);
    chk("t1_data_stable_cycles", ok, FDIV);

    // Three empty frames after that sample.
    chk("t4_ucnt_a", underrun_cnt, 2);
    chk("t4_ldata_a", Ldata, UR_L);
    next_fcnt0();
    @(negedge clk);
    chk("t4_ucnt_b", underrun_cnt, 3);
    next_fcnt0();
    @(negedge clk);
    chk("t4_ucnt_c", underrun_cnt, 4);
    chk("t4_underrun", underrun, 1);
    chk("t4_ldata_c", Ldata, UR_L);
    chk("t4_rdata_c", Rdata, UR_R);

    // Round-robin with both sources always valid.
    RST = 1'b1; en = 1'b0;
    cyc(2);
    RST = 1'b0;
    @(negedge clk);
    en = 1'b1; mode = 2'b10;
    src0_valid = 1'b1; src0_l = 24'hA0A0A0; src0_r = 24'hA1A1A1;
    src1_valid = 1'b1; src1_l = 24'hB0B0B0; src1_r = 24'hB1B1B1;
    #1;
    chk("t2_first_grant_r0", src0_ready, 1);
    chk("t2_first_grant_r1", src1_ready, 0);
    @(negedge clk);
    chk("t2_second_grant_r0", src0_ready, 0);
    chk("t2_second_grant_r1", src1_ready, 1);
    cyc(3);
    chk("t2_level_full", fifo_level, 4);
    chk("t2_full_r0", src0_ready, 0);
    chk("t2_full_r1", src1_ready, 0);
    next_fcnt0();
    chk("t5_pop_cycle_r0", src0_ready, 0);
    chk("t5_pop_cycle_r1", src1_ready, 0);
    @(negedge clk);
    chk("t5_level_after_pop", fifo_level, 3);
    chk("t2_pop0_ldata", Ldata, 24'hA0A0A0);
    chk("t2_pop0_rdata", Rdata, 24'hA1A1A1);
    chk("t5_after_pop_r0", src0_ready, 1);
    chk("t5_after_pop_r1", src1_ready, 0);
    @(negedge clk);
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    chk("t2_refill_level", fifo_level, 4);
    exp_q.push_back({24'hB0B0B0, 24'hB1B1B1});
    exp_q.push_back({24'hA0A0A0, 24'hA1A1A1});
    exp_q.push_back({24'hB0B0B0, 24'hB1B1B1});
    exp_q.push_back({24'hA0A0A0, 24'hA1A1A1});
    while (exp_q.size() > 0) begin
      exp_e = exp_q.pop_front();
      next_fcnt0();
      @(negedge clk);
      chk("t2_order_ldata", Ldata, exp_e[2*DW-1:DW]);
      chk("t2_order_rdata", Rdata, exp_e[DW-1:0]);
    end
    chk("t2_drained_level", fifo_level, 0);

    // Reset mid-frame with two entries queued, then en low for 10 cycles.
    mode = 2'b00;
    src0_valid = 1'b1; src0_l = 24'h111111; src0_r = 24'h222222;
    cyc(2);
    chk("t6_level_before_rst", fifo_level, 2);
    RST = 1'b1; en = 1'b0;
    @(negedge clk);
    RST = 1'b0;
    cyc(10);
    chk("t6_ldata", Ldata, 0);
    chk("t6_rdata", Rdata, 0);
    chk("t6_sclk", sample_clk, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_underrun", underrun, 0);
    chk("t6_ucnt", underrun_cnt, 0);
    chk("t6_ready0", src0_ready, 0);
    chk("t6_ready1", src1_ready, 0);

    // Mix mode: four joint pushes starting on the first enabled cycle.
    en = 1'b1; mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      src0_valid = 1'b1; src0_l = mix_tbl[i].l0; src0_r = mix_tbl[i].r0;
      src1_valid = 1'b1; src1_l = mix_tbl[i].l1; src1_r = mix_tbl[i].r1;
      #1;
      chk($sformatf("t3_joint_ready%0d", i), {src0_ready, src1_ready}, 2'b11);
      @(negedge clk);
      if (i == 0) begin
        chk("t6_first_frame_underrun", underrun_cnt, 1);
        chk("t6_first_frame_ldata", Ldata, 0);
      end
    end
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    chk("t3_level", fifo_level, 4);
    for (int i = 0; i < 4; i++) begin
      next_fcnt0();
      @(negedge clk);
      chk($sformatf("t3_mix%0d_ldata", i), Ldata, mix_tbl[i].exp_l);
      chk($sformatf("t3_mix%0d_rdata", i), Rdata, mix_tbl[i].exp_r);
    end
    chk("t3_ucnt_final", underrun_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
